core_mem_wb_bridge: RTL and testbench
=====================================

Name: core_mem_wb_bridge

Overview:
- Parametrised successor to the ad-hoc core-to-Wishbone glue in the processorci_top wrappers.
- Converts a core-side req/resp memory port (req, cmd, width, addr, wdata → rdata, resp, err) into a single-outstanding Wishbone classic master cycle.
- Adds byte-lane select generation, store-data replication, load-lane extraction, misalignment detection, bus-error forwarding, a watchdog timeout and a selectable response register stage.
- One instance per memory port (instruction and data) between core and Controller.

Parameters:
- DATA_WIDTH, 32, bus data width; 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- RESP_REG, 1, 1 = resp/rdata/err registered one cycle after ack; 0 = combinational in the ack cycle.
- TIMEOUT_CYCLES, 255, cycles in BUS before forced error; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  request valid; core holds req and all fields stable until resp
- cmd  in  1  1 = write, 0 = read
- width  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_WIDTH=64)
- addr  in  ADDR_WIDTH  byte address
- wdata  in  DATA_WIDTH  store data, LSB-aligned
- rdata  out  DATA_WIDTH  load data, LSB-aligned, zero-extended
- resp  out  1  one-cycle completion pulse
- err  out  1  valid with resp; 1 = misaligned, illegal width, bus error or timeout
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe; always equal to wb_cyc_o
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  DATA_WIDTH/8  byte-lane select
- wb_addr_o  out  ADDR_WIDTH  address with low log2(DATA_WIDTH/8) bits forced to 0
- wb_data_o  out  DATA_WIDTH  write data
- wb_data_i  in  DATA_WIDTH  read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; timeout counter is 0.
- Reset is asynchronous: asserting rst_n mid-cycle drops wb_cyc_o/wb_stb_o immediately and discards the pending transaction, with no resp.
- IDLE state:
  - req is sampled only in IDLE.
  - Illegal request (width=11 with DATA_WIDTH=32; half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0): go to RESP with err=1. No bus cycle is issued.
  - Legal request: register we, sel, addr and data; go to BUS. wb_cyc_o rises in the next cycle.
- Lane offset off = addr[log2(DATA_WIDTH/8)-1:0].
- wb_sel_o: byte = 1<<off; half = 2'b11<<off; word = 4'hF<<off; dword = all ones.
- wb_data_o: wdata low byte/half/word replicated across every lane; dword passes through unchanged.
- BUS state:
  - wb_cyc_o/wb_stb_o and all wb outputs are held constant until ack, err or timeout.
  - The timeout counter increments each BUS cycle.
  - ack: capture rdata = (wb_data_i >> 8*off), masked to the access width; err=0.
  - wb_err_i (priority over ack if both are high): rdata=0, err=1.
  - Counter reaches TIMEOUT_CYCLES (nonzero) with no ack/err: err=1, rdata=0.
  - On exit, wb_cyc_o drops the next cycle.
- RESP_REG=1: go to RESP. resp is high for exactly one cycle, the cycle after the terminating ack/err/timeout, then return to IDLE.
- RESP_REG=0: resp/err/rdata are driven combinationally in the ack/err cycle; return directly to IDLE.
- RESP state: ignores req. The core drops req, or presents a new request, in the cycle after resp; it is sampled in IDLE.
- Latency, RESP_REG=1, zero-wait slave: req at cycle 0, cyc at cycle 1, ack at cycle 1, resp at cycle 2.
- wb_ack_i or wb_err_i arriving outside BUS is ignored.
- rdata holds its last value between responses. It is meaningful only when resp=1 and err=0.

Decomposition:
- Package core_mem_pkg:
  - width_e {W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10, W_DWORD=2'b11}.
  - bridge_state_e {IDLE, BUS, RESP}.
  - Functions lane_sel(), wdata_replicate(), rdata_extract(), misaligned().
- One sub-module, core_mem_lane_align: purely combinational sel, replicate and extract logic, parametrised by DATA_WIDTH and reused by both bridge instances.

Test Plan:
- Word read: addr 0x100, slave acks 3 cycles after cyc with 0xDEADBEEF. Expect sel=4'hF, we=0, rdata=0xDEADBEEF, err=0, resp one cycle after ack (RESP_REG=1).
- Byte write: addr 0x103, wdata 0x000000AB. Expect wb_sel_o=4'b1000, wb_data_o=0xABABABAB, wb_we_o=1, wb_addr_o=0x100.
- Half read: addr 0x102, wb_data_i=0x12345678. Expect rdata=0x00001234. Repeat with RESP_REG=0: resp coincides with ack.
- Misaligned half: addr 0x101. Expect wb_cyc_o stays 0, resp=1 and err=1 one cycle after req.
- Timeout: TIMEOUT_CYCLES=8, slave never acks. Expect cyc high 8 cycles then low, resp with err=1. Also wb_err_i pulse: err=1, rdata=0.
- Reset in BUS: drop rst_n two cycles into a read. Expect wb_cyc_o=0 immediately and no resp. After release, a new word read completes normally. With DATA_WIDTH=64, a dword read at 0x8 yields sel=8'hFF.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types and lane helpers for the core-to-Wishbone memory bridge.
// Helpers operate at the widest supported bus; callers truncate to their width.
package core_mem_pkg;

    localparam int MAX_DW   = 64;
    localparam int MAX_SELW = MAX_DW / 8;

    typedef enum logic [1:0] {
        W_BYTE  = 2'b00,
        W_HALF  = 2'b01,
        W_WORD  = 2'b10,
        W_DWORD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } bridge_state_e;

    function automatic logic [MAX_SELW-1:0] lane_sel(width_e w, logic [2:0] off);
        logic [MAX_SELW-1:0] s;
        case (w)
            W_BYTE:  s = 8'h01 << off;
            W_HALF:  s = 8'h03 << off;
            W_WORD:  s = 8'h0F << off;
            default: s = '1;
        endcase
        return s;
    endfunction

    function automatic logic [MAX_DW-1:0] wdata_replicate(width_e w, logic [MAX_DW-1:0] d);
        logic [MAX_DW-1:0] r;
        case (w)
            W_BYTE:  r = {8{d[7:0]}};
            W_HALF:  r = {4{d[15:0]}};
            W_WORD:  r = {2{d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [MAX_DW-1:0] rdata_extract(width_e w, logic [2:0] off,
                                                        logic [MAX_DW-1:0] d);
        logic [MAX_DW-1:0] s;
        logic [MAX_DW-1:0] r;
        s = d >> {off, 3'b000};
        case (w)
            W_BYTE:  r = {56'd0, s[7:0]};
            W_HALF:  r = {48'd0, s[15:0]};
            W_WORD:  r = {32'd0, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // A dword access is only legal on a 64-bit bus.
    function automatic logic misaligned(width_e w, logic [2:0] lo, logic dw64);
        logic m;
        case (w)
            W_BYTE:  m = 1'b0;
            W_HALF:  m = lo[0];
            W_WORD:  m = |lo[1:0];
            default: m = !dw64 || (|lo);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/core_mem_wb_bridge_if.sv
// Wishbone classic bus between the bridge (master) and the controller (slave).
interface core_mem_wb_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [ADDR_WIDTH-1:0]   wb_addr_o;
    logic [DATA_WIDTH-1:0]   wb_data_o;
    logic [DATA_WIDTH-1:0]   wb_data_i;
    logic                    wb_ack_i;
    logic                    wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
        input  wb_data_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
        output wb_data_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/core_mem_lane_align.sv
// Combinational byte-lane logic: select generation, store replication, load extraction.
module core_mem_lane_align
    import core_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)(
    input  width_e                  req_width,
    input  logic [2:0]              req_off,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] sel,
    output logic [DATA_WIDTH-1:0]   wdata_rep,
    input  width_e                  rsp_width,
    input  logic [2:0]              rsp_off,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic [DATA_WIDTH-1:0]   rdata_ext
);
    localparam int SELW = DATA_WIDTH / 8;

    assign sel       = SELW'(lane_sel(req_width, req_off));
    assign wdata_rep = DATA_WIDTH'(wdata_replicate(req_width, MAX_DW'(wdata)));
    assign rdata_ext = DATA_WIDTH'(rdata_extract(rsp_width, rsp_off, MAX_DW'(bus_rdata)));

endmodule

// File: rtl/core_mem_wb_bridge.sv
// Core req/resp memory port to single-outstanding Wishbone classic master,
// with alignment checks, bus-error forwarding, watchdog and optional response register.
module core_mem_wb_bridge
    import core_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int RESP_REG       = 1,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  cmd,
    input  logic [1:0]            width,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  resp,
    output logic                  err,
    core_mem_wb_bridge_if.master  wb
);
    localparam int  SELW      = DATA_WIDTH / 8;
    localparam int  OFFW      = $clog2(SELW);
    localparam int  CNTW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int  TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TO_LAST_I);
    localparam logic DW64     = (DATA_WIDTH == 64);

    bridge_state_e         state_q, state_d;
    logic                  we_q, we_d;
    logic [SELW-1:0]       sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    width_e                width_q, width_d;
    logic [2:0]            off_q, off_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    width_e                req_width;
    logic [2:0]            req_off;
    logic                  illegal;
    logic [SELW-1:0]       sel_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] rdata_new;
    logic                  term;
    logic                  term_err;
    logic [DATA_WIDTH-1:0] term_data;

    assign req_width = width_e'(width);
    assign req_off   = 3'(addr[OFFW-1:0]);
    assign illegal   = misaligned(req_width, addr[2:0], DW64);

    core_mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
        .req_width (req_width),
        .req_off   (req_off),
        .wdata     (wdata),
        .sel       (sel_new),
        .wdata_rep (wdata_new),
        .rsp_width (width_q),
        .rsp_off   (off_q),
        .bus_rdata (wb.wb_data_i),
        .rdata_ext (rdata_new)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        width_d   = width_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        term      = 1'b0;
        term_err  = 1'b0;
        term_data = '0;
        resp      = 1'b0;
        err       = 1'b0;
        rdata     = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        we_d              = cmd;
                        sel_d             = sel_new;
                        addr_d            = addr;
                        addr_d[OFFW-1:0]  = '0;
                        data_d            = wdata_new;
                        width_d           = req_width;
                        off_d             = req_off;
                        cnt_d             = '0;
                        state_d           = BUS;
                    end
                end
            end
            BUS: begin
                // Bus error wins over a simultaneous ack.
                if (wb.wb_err_i) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end else if (wb.wb_ack_i) begin
                    term      = 1'b1;
                    term_data = rdata_new;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (term) begin
                    cnt_d   = '0;
                    err_d   = term_err;
                    rdata_d = term_data;
                    if (RESP_REG != 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = IDLE;
                        resp    = 1'b1;
                        err     = term_err;
                        rdata   = term_data;
                    end
                end
            end
            RESP: begin
                resp    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            width_q <= W_BYTE;
            off_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            width_q <= width_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign wb.wb_cyc_o  = (state_q == BUS);
    assign wb.wb_stb_o  = (state_q == BUS);
    assign wb.wb_we_o   = we_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_data_o = data_q;

endmodule

// File: tb/tb_core_mem_wb_bridge.sv
// Bench for core_mem_wb_bridge: three instances (32-bit registered, 32-bit combinational,
// 64-bit registered) driven by directed and random transactions against a byte-lane model.
module tb_core_mem_wb_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        req_v   [3];
    logic        cmd_v   [3];
    logic [1:0]  width_v [3];
    logic [31:0] addr_v  [3];
    logic [63:0] wdata_v [3];
    logic        ack_v   [3];
    logic        werr_v  [3];
    logic [63:0] dati_v  [3];

    logic [31:0] rdata_a, rdata_b;
    logic [63:0] rdata_c;
    logic        resp_a, resp_b, resp_c;
    logic        err_a, err_b, err_c;

    core_mem_wb_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
    core_mem_wb_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();
    core_mem_wb_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus_c ();

    assign bus_a.wb_data_i = dati_v[0][31:0];
    assign bus_a.wb_ack_i  = ack_v[0];
    assign bus_a.wb_err_i  = werr_v[0];
    assign bus_b.wb_data_i = dati_v[1][31:0];
    assign bus_b.wb_ack_i  = ack_v[1];
    assign bus_b.wb_err_i  = werr_v[1];
    assign bus_c.wb_data_i = dati_v[2];
    assign bus_c.wb_ack_i  = ack_v[2];
    assign bus_c.wb_err_i  = werr_v[2];

    core_mem_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_REG(1), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .cmd(cmd_v[0]), .width(width_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0][31:0]), .rdata(rdata_a), .resp(resp_a),
        .err(err_a), .wb(bus_a));

    core_mem_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_REG(0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .cmd(cmd_v[1]), .width(width_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1][31:0]), .rdata(rdata_b), .resp(resp_b),
        .err(err_b), .wb(bus_b));

    core_mem_wb_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .RESP_REG(1), .TIMEOUT_CYCLES(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .cmd(cmd_v[2]), .width(width_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata_c), .resp(resp_c),
        .err(err_c), .wb(bus_c));

    // Instance configuration as seen by the bench.
    function automatic int dw_of(int d); return (d == 2) ? 64 : 32; endfunction
    function automatic bit rr_of(int d); return (d != 1); endfunction
    function automatic int to_of(int d); return (d == 2) ? 16 : 8; endfunction

    function automatic logic g_cyc(int d);
        return (d == 0) ? bus_a.wb_cyc_o : (d == 1) ? bus_b.wb_cyc_o : bus_c.wb_cyc_o;
    endfunction
    function automatic logic g_stb(int d);
        return (d == 0) ? bus_a.wb_stb_o : (d == 1) ? bus_b.wb_stb_o : bus_c.wb_stb_o;
    endfunction
    function automatic logic g_we(int d);
        return (d == 0) ? bus_a.wb_we_o : (d == 1) ? bus_b.wb_we_o : bus_c.wb_we_o;
    endfunction
    function automatic logic g_resp(int d);
        return (d == 0) ? resp_a : (d == 1) ? resp_b : resp_c;
    endfunction
    function automatic logic g_err(int d);
        return (d == 0) ? err_a : (d == 1) ? err_b : err_c;
    endfunction
    function automatic logic [63:0] g_rdata(int d);
        return (d == 0) ? 64'(rdata_a) : (d == 1) ? 64'(rdata_b) : rdata_c;
    endfunction
    function automatic logic [63:0] g_sel(int d);
        return (d == 0) ? 64'(bus_a.wb_sel_o) : (d == 1) ? 64'(bus_b.wb_sel_o) : 64'(bus_c.wb_sel_o);
    endfunction
    function automatic logic [63:0] g_addr(int d);
        return (d == 0) ? 64'(bus_a.wb_addr_o) : (d == 1) ? 64'(bus_b.wb_addr_o) : 64'(bus_c.wb_addr_o);
    endfunction
    function automatic logic [63:0] g_wdo(int d);
        return (d == 0) ? 64'(bus_a.wb_data_o) : (d == 1) ? 64'(bus_b.wb_data_o) : bus_c.wb_data_o;
    endfunction

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // Reference: lanes are byte indices; an access covers 'bytes' lanes starting at the offset.
    function automatic void model(input int d, input logic [1:0] w, input logic [31:0] a,
                                  input logic [63:0] wd, input logic [63:0] rd,
                                  output bit ill, output logic [63:0] es, output logic [63:0] ea,
                                  output logic [63:0] ewd, output logic [63:0] erd);
        int nb;
        int bytes;
        int off;
        nb    = dw_of(d) / 8;
        bytes = 1 << w;
        off   = int'(a[2:0]) % nb;
        ill   = (bytes > nb) || ((int'(a[2:0]) % bytes) != 0);
        es    = '0;
        ewd   = '0;
        erd   = '0;
        for (int i = 0; i < nb; i++) begin
            es[i]         = (i >= off) && (i < off + bytes);
            ewd[8*i +: 8] = wd[8*(i % bytes) +: 8];
        end
        for (int i = 0; i < bytes && off + i < nb; i++)
            erd[8*i +: 8] = rd[8*(off+i) +: 8];
        ea = 64'(a - 32'(off));
    endfunction

    // mode: 0 = slave acks after lat cycles, 1 = slave errors, 2 = slave never answers.
    task automatic txn(input int d, input bit c, input logic [1:0] w, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input int lat, input int mode);
        bit          ill;
        logic [63:0] es, ea, ewd, erd, exp_rd;
        int          n;
        model(d, w, a, wd, rd, ill, es, ea, ewd, erd);
        exp_rd = (mode == 0) ? erd : 64'd0;
        @(negedge clk);
        req_v[d]   = 1'b1;
        cmd_v[d]   = c;
        width_v[d] = w;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        dati_v[d]  = rd;
        if (ill) begin
            @(negedge clk);
            chk(d, "ill_cyc", g_cyc(d), 1'b0);
            chk(d, "ill_resp", g_resp(d), 1'b1);
            chk(d, "ill_err", g_err(d), 1'b1);
            req_v[d] = 1'b0;
            @(negedge clk);
            chk(d, "ill_resp_end", g_resp(d), 1'b0);
            return;
        end
        n = 0;
        @(negedge clk);
        while (!g_cyc(d) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(d, "cyc_delay", n, 0);
        chk(d, "stb", g_stb(d), 1'b1);
        chk(d, "we", g_we(d), c);
        chk(d, "sel", g_sel(d), es);
        chk(d, "addr", g_addr(d), ea);
        if (c) chk(d, "wdata", g_wdo(d), ewd);
        if (mode == 2) begin
            n = 1;
            while (n < 64) begin
                @(negedge clk);
                if (!g_cyc(d)) break;
                n++;
            end
            chk(d, "to_len", n, to_of(d));
            chk(d, "to_resp", g_resp(d), 1'b1);
            chk(d, "to_err", g_err(d), 1'b1);
            chk(d, "to_rdata", g_rdata(d), 64'd0);
            req_v[d] = 1'b0;
            @(negedge clk);
            chk(d, "to_resp_end", g_resp(d), 1'b0);
            return;
        end
        repeat (lat) @(negedge clk);
        chk(d, "cyc_hold", g_cyc(d), 1'b1);
        chk(d, "resp_early", g_resp(d), 1'b0);
        if (mode == 1) werr_v[d] = 1'b1;
        else           ack_v[d]  = 1'b1;
        #1;
        if (!rr_of(d)) begin
            chk(d, "comb_resp", g_resp(d), 1'b1);
            chk(d, "comb_err", g_err(d), (mode == 1));
            chk(d, "comb_rdata", g_rdata(d), exp_rd);
        end else begin
            chk(d, "reg_resp_wait", g_resp(d), 1'b0);
        end
        @(negedge clk);
        ack_v[d]  = 1'b0;
        werr_v[d] = 1'b0;
        chk(d, "cyc_drop", g_cyc(d), 1'b0);
        if (rr_of(d)) begin
            chk(d, "reg_resp", g_resp(d), 1'b1);
            chk(d, "reg_err", g_err(d), (mode == 1));
            chk(d, "reg_rdata", g_rdata(d), exp_rd);
            req_v[d] = 1'b0;
            @(negedge clk);
        end else begin
            req_v[d] = 1'b0;
        end
        chk(d, "resp_one_cycle", g_resp(d), 1'b0);
        chk(d, "rdata_hold", g_rdata(d), exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          d;
        int          mode;
        logic [1:0]  w;
        logic [31:0] a;
        logic [63:0] wd, rd;
        bit          seen;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0; cmd_v[i] = 1'b0; width_v[i] = 2'b00; addr_v[i] = '0;
            wdata_v[i] = '0; ack_v[i] = 1'b0; werr_v[i] = 1'b0; dati_v[i] = '0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk(i, "rst_cyc", g_cyc(i), 1'b0);
            chk(i, "rst_resp", g_resp(i), 1'b0);
            chk(i, "rst_err", g_err(i), 1'b0);
            chk(i, "rst_rdata", g_rdata(i), 64'd0);
            chk(i, "rst_sel", g_sel(i), 64'd0);
            chk(i, "rst_addr", g_addr(i), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 1'b0, 2'b10, 32'h100, 64'd0, 64'hDEADBEEF, 3, 0);
        txn(0, 1'b1, 2'b00, 32'h103, 64'hAB, 64'd0, 0, 0);
        txn(0, 1'b0, 2'b01, 32'h102, 64'd0, 64'h12345678, 1, 0);
        txn(1, 1'b0, 2'b01, 32'h102, 64'd0, 64'h12345678, 2, 0);
        txn(0, 1'b0, 2'b01, 32'h101, 64'd0, 64'd0, 0, 0);
        txn(0, 1'b0, 2'b10, 32'h104, 64'd0, 64'h11111111, 0, 2);
        txn(0, 1'b0, 2'b10, 32'h108, 64'd0, 64'hCAFEF00D, 1, 1);
        txn(1, 1'b0, 2'b00, 32'h105, 64'd0, 64'h87654321, 0, 1);
        txn(1, 1'b0, 2'b11, 32'h0, 64'd0, 64'd0, 0, 0);
        txn(2, 1'b0, 2'b11, 32'h8, 64'd0, 64'h0123456789ABCDEF, 0, 0);
        txn(2, 1'b1, 2'b01, 32'h6, 64'h1234, 64'd0, 1, 0);
        txn(2, 1'b0, 2'b10, 32'h20, 64'd0, 64'd0, 0, 2);

        // Asynchronous reset in the middle of a bus cycle.
        @(negedge clk);
        req_v[0] = 1'b1; cmd_v[0] = 1'b0; width_v[0] = 2'b10; addr_v[0] = 32'h200;
        @(negedge clk);
        chk(0, "rstbus_cyc_up", g_cyc(0), 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(0, "rstbus_cyc", g_cyc(0), 1'b0);
        chk(0, "rstbus_stb", g_stb(0), 1'b0);
        req_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (g_resp(0) || g_cyc(0)) seen = 1'b1;
        end
        chk(0, "rstbus_no_resp", seen, 1'b0);
        txn(0, 1'b0, 2'b10, 32'h100, 64'd0, 64'h55AA33CC, 0, 0);

        for (int k = 0; k < 60; k++) begin
            d    = $urandom_range(0, 2);
            w    = 2'($urandom_range(0, 3));
            a    = $urandom & 32'h0000_FFFF;
            wd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (rr_of(d) && $urandom_range(0, 11) == 0) mode = 2;
            txn(d, 1'($urandom_range(0, 1)), w, a, wd, rd, $urandom_range(0, 3), mode);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
